// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> [MEM] -> WB, with an absorbing HALT.
// Define CPU_SEQ_PERF_CNT_EN to build the cycle and retired-instruction counters in.
module cpu_seq (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   input  logic        i_imem_ack,
   output logic        o_ir_we,
   input  logic        i_is_store,
   input  logic        i_is_load,
   input  logic        i_is_branch,
   input  logic        i_is_jump,
   input  logic        i_wb_en,
   input  logic        i_illegal,
   input  logic        i_cmp_res,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   input  logic        i_dmem_ack,
   output logic        o_pc_we,
   output logic        o_pc_sel,
   output logic        o_rf_we,
   output logic        o_retire,
   output logic        o_halted,
   output logic [2:0]  o_state,
   output logic [31:0] o_cycle_cnt,
   output logic [31:0] o_instret
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_MEM   = 3'd2,
      ST_WB    = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   state_t state, state_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: if (i_imem_ack) state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (i_illegal)                    state_nxt = ST_HALT;
            else if (i_is_load || i_is_store) state_nxt = ST_MEM;
            else                              state_nxt = ST_WB;
         end
         ST_MEM:  if (i_dmem_ack) state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_FETCH;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_FETCH;
      endcase
   end

   // Strobes are also qualified by i_rst_n so a reset drops requests before any clock edge.
   always_comb begin
      o_imem_req = 1'b0;
      o_ir_we    = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_pc_we    = 1'b0;
      o_pc_sel   = 1'b0;
      o_rf_we    = 1'b0;
      o_retire   = 1'b0;
      o_halted   = 1'b0;
      if (i_rst_n) begin
         case (state)
            ST_FETCH: begin
               o_imem_req = 1'b1;
               o_ir_we    = i_imem_ack;
            end
            ST_MEM: begin
               o_dmem_req = 1'b1;
               o_dmem_we  = i_is_store;
            end
            ST_WB: begin
               o_pc_we  = 1'b1;
               o_retire = 1'b1;
               o_rf_we  = i_wb_en & ~i_is_store;
               o_pc_sel = i_is_jump | (i_is_branch & i_cmp_res);
            end
            ST_HALT:  o_halted = 1'b1;
            default:  ;
         endcase
      end
   end

   assign o_state = state;

`ifdef CPU_SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instret;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cycle_cnt <= '0;
         instret   <= '0;
      end else begin
         if (state != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
         if (o_retire)         instret   <= instret + 32'd1;
      end
   end

   assign o_cycle_cnt = cycle_cnt;
   assign o_instret   = instret;
`else
   assign o_cycle_cnt = '0;
   assign o_instret   = '0;
`endif

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port o_imem_req, output, 1 bit: instruction fetch request.
REQ-004 SHALL have port i_imem_ack, input, 1 bit: fetch complete; instruction word valid this cycle.
REQ-005 SHALL have port o_ir_we, output, 1 bit: instruction register load strobe.
REQ-006 SHALL have ports i_is_store, i_is_load, i_is_branch, i_is_jump, i_wb_en, i_illegal, inputs, 1 bit each: decoder outputs for the current IR.
REQ-007 SHALL have port i_cmp_res, input, 1 bit: comparator result for the branch condition.
REQ-008 SHALL have port o_dmem_req, output, 1 bit: data memory request.
REQ-009 SHALL have port o_dmem_we, output, 1 bit: data write (store) qualifier for o_dmem_req.
REQ-010 SHALL have port i_dmem_ack, input, 1 bit: data access complete; load data valid this cycle.
REQ-011 SHALL have port o_pc_we, output, 1 bit: PC update strobe.
REQ-012 SHALL have port o_pc_sel, output, 1 bit: PC source select; 0 = PC+4, 1 = ALU target.
REQ-013 SHALL have port o_rf_we, output, 1 bit: register file write strobe.
REQ-014 SHALL have port o_retire, output, 1 bit: one-cycle pulse per completed instruction.
REQ-015 SHALL have port o_halted, output, 1 bit: sequencer is in HALT.
REQ-016 SHALL have port o_state, output, 3 bits: state code; FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4.
REQ-017 SHALL have ports o_cycle_cnt and o_instret, outputs, 32 bits each: performance counters (see Configuration).

Function
REQ-018 SHALL implement a Moore FSM with states FETCH, EXEC, MEM, WB and HALT; all strobes SHALL be decoded from the registered state plus the listed inputs.
REQ-019 FETCH: SHALL hold o_imem_req=1 until i_imem_ack; on ack, SHALL assert o_ir_we the same cycle and go to EXEC; without ack, SHALL stay in FETCH.
REQ-020 EXEC: if i_illegal, SHALL go to HALT (i_illegal has priority); else if i_is_load or i_is_store, SHALL go to MEM; else SHALL go to WB.
REQ-021 MEM: SHALL hold o_dmem_req=1 with o_dmem_we=i_is_store stable until i_dmem_ack; on ack, SHALL go to WB.
REQ-022 WB: SHALL assert o_pc_we=1 and o_retire=1, SHALL assert o_rf_we=i_wb_en AND NOT i_is_store, SHALL drive o_pc_sel=i_is_jump OR (i_is_branch AND i_cmp_res), and SHALL go to FETCH.
REQ-023 HALT: SHALL be absorbing until reset, with o_halted=1 and every other strobe 0.
REQ-024 Outside their designated state, o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we, o_rf_we, o_retire and o_pc_sel SHALL be 0.
REQ-025 An ack arriving while the matching request is low SHALL be ignored; ack in the first request cycle SHALL be legal (zero wait).
REQ-026 Minimum latency SHALL be 3 cycles for a non-memory instruction and 4 cycles for a load or store; each wait cycle SHALL add 1.

Reset
REQ-027 Asserting i_rst_n=0 SHALL force state FETCH and clear the counters immediately, regardless of the clock.
REQ-028 While in reset, all outputs SHALL be 0 and o_state SHALL be 0.
REQ-029 Reset asserted mid-request SHALL drop o_imem_req/o_dmem_req at once without retiring.
REQ-030 The first o_imem_req SHALL appear in the first cycle after reset release.

Configuration
REQ-031 The macro CPU_SEQ_PERF_CNT_EN SHALL compile the performance counters in.
REQ-032 With CPU_SEQ_PERF_CNT_EN defined: o_cycle_cnt SHALL increment every cycle not in HALT; o_instret SHALL increment on o_retire; both SHALL wrap from 2^32-1 to 0.
REQ-033 Without CPU_SEQ_PERF_CNT_EN: the ports SHALL remain, driven to constant 0, with no counter registers.

Verification
REQ-034 ADD with zero-wait ack -> o_state 0,1,3,0; o_rf_we=1 and o_retire=1 in cycle 3; o_pc_sel=0.
REQ-035 SW with i_dmem_ack delayed 2 cycles -> o_dmem_req=1 and o_dmem_we=1 stable for 3 cycles; o_rf_we=0 in WB; total 6 cycles.
REQ-036 BEQ taken (i_cmp_res=1) then not taken (i_cmp_res=0) -> o_pc_sel=1 then 0 in the respective WB cycles; o_rf_we=0 for both.
REQ-037 i_illegal=1 in EXEC -> o_halted=1 from the next cycle; no o_pc_we pulse; o_cycle_cnt frozen; stray acks ignored.
REQ-038 i_rst_n pulsed low mid-MEM -> o_dmem_req=0 asynchronously; after release, o_state=0 and o_imem_req=1; counters=0.
REQ-039 With CPU_SEQ_PERF_CNT_EN, o_instret forced to 32'hFFFFFFFF, then one retire -> 0; without the macro, both counters read 0 throughout.
